// File: rtl/vehicle_pkg.sv
// Shared vehicle definitions: gear codes, reject codes, sequencer state encoding
// and the decoded shift request kind.
package vehicle_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    localparam logic [1:0] REJ_BRAKE  = 2'd0;
    localparam logic [1:0] REJ_SPEED  = 2'd1;
    localparam logic [1:0] REJ_BUSY   = 2'd2;
    localparam logic [1:0] REJ_ENGINE = 2'd3;

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_SHIFT  = 1'b1;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_UP,
        REQ_DOWN,
        REQ_PARK
    } req_kind_t;

    // P and R may only be engaged with the vehicle at a standstill.
    function automatic logic needs_standstill(input logic [3:0] gear);
        return (gear == GEAR_P) || (gear == GEAR_R);
    endfunction

endpackage

// File: rtl/gear_interlock_check.sv
// Combinational interlock: resolves a decoded request against the current gear
// into a target gear and either an accept or the first failing reject code.
module gear_interlock_check
    import vehicle_pkg::*;
(
    input  logic [3:0] gear,
    input  req_kind_t  req,
    input  logic       brake,
    input  logic [7:0] speed,
    input  logic       engine_on,
    input  logic       last_fwd,
    output logic       live,
    output logic       accept,
    output logic [3:0] target,
    output logic [1:0] code
);

    always_comb begin
        live   = 1'b0;
        target = gear;
        case (req)
            REQ_PARK: begin
                target = GEAR_P;
                live   = (gear != GEAR_P);
            end
            REQ_UP: begin
                case (gear)
                    GEAR_P:  target = GEAR_R;
                    GEAR_R:  target = GEAR_N;
                    GEAR_N:  target = GEAR_D;
                    default: target = gear;
                endcase
                live = (gear != GEAR_D);
            end
            REQ_DOWN: begin
                case (gear)
                    GEAR_D:  target = GEAR_N;
                    GEAR_N:  target = GEAR_R;
                    GEAR_R:  target = GEAR_P;
                    default: target = gear;
                endcase
                live = (gear != GEAR_P);
            end
            default: live = 1'b0;
        endcase
    end

    // First failing rule wins; a request past the end of the range is not live.
    always_comb begin
        accept = 1'b0;
        code   = REJ_BRAKE;
        if (live) begin
            if (!engine_on)
                code = REJ_ENGINE;
            else if (gear == GEAR_P && !brake)
                code = REJ_BRAKE;
            else if (needs_standstill(target) && speed != 8'd0)
                code = REJ_SPEED;
            else if (gear == GEAR_N && target == GEAR_D && speed != 8'd0 && !last_fwd)
                code = REJ_SPEED;
            else
                accept = 1'b1;
        end
    end

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear selector sequencer: interlocked shift requests, timed neutral phase,
// engine-off and fuel-out safe gears, and registered reject reporting.
module gear_shift_ctrl
    import vehicle_pkg::*;
#(
    parameter int SHIFT_TICKS = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       engine_on,
    input  logic       tick_speed,
    input  logic       req_up,
    input  logic       req_down,
    input  logic       req_park,
    input  logic       brake,
    input  logic [7:0] speed,
    input  logic [7:0] fuel,
    output logic [3:0] current_gear,
    output logic       shift_busy,
    output logic       shift_reject,
    output logic [1:0] reject_code
);

    localparam logic [CNT_W-1:0] TICK_SAT  = CNT_W'(SHIFT_TICKS);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SHIFT_TICKS - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       target;
    logic [3:0]       eff_target;
    logic             last_fwd;
    req_kind_t        req;
    logic             req_live;
    logic             req_accept;
    logic [3:0]       req_target;
    logic [1:0]       req_code;

    // Park dominates; simultaneous up and down cancel each other silently.
    always_comb begin
        req = REQ_NONE;
        if (req_park)
            req = REQ_PARK;
        else if (req_up && !req_down)
            req = REQ_UP;
        else if (req_down && !req_up)
            req = REQ_DOWN;
    end

    gear_interlock_check u_check (
        .gear      (current_gear),
        .req       (req),
        .brake     (brake),
        .speed     (speed),
        .engine_on (engine_on),
        .last_fwd  (last_fwd),
        .live      (req_live),
        .accept    (req_accept),
        .target    (req_target),
        .code      (req_code)
    );

    // Running out of fuel mid-shift turns a drive-type target into neutral.
    assign eff_target = (fuel == 8'd0 && (target == GEAR_D || target == GEAR_R))
                        ? GEAR_N : target;

    assign shift_busy = (state == ST_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_STABLE;
            cnt          <= '0;
            target       <= GEAR_P;
            last_fwd     <= 1'b0;
            current_gear <= GEAR_P;
            shift_reject <= 1'b0;
            reject_code  <= REJ_BRAKE;
        end else begin
            shift_reject <= 1'b0;

            if (current_gear == GEAR_D)
                last_fwd <= 1'b1;
            else if (current_gear == GEAR_R)
                last_fwd <= 1'b0;

            if (!engine_on) begin
                state        <= ST_STABLE;
                cnt          <= '0;
                current_gear <= GEAR_P;
                if (state == ST_STABLE && req_live) begin
                    shift_reject <= 1'b1;
                    reject_code  <= REJ_ENGINE;
                end
            end else if (state == ST_STABLE) begin
                if (fuel == 8'd0 && (current_gear == GEAR_D || current_gear == GEAR_R)) begin
                    current_gear <= GEAR_N;
                end else if (req_live) begin
                    if (req_accept) begin
                        state        <= ST_SHIFT;
                        current_gear <= GEAR_N;
                        target       <= req_target;
                        cnt          <= '0;
                    end else begin
                        shift_reject <= 1'b1;
                        reject_code  <= req_code;
                    end
                end
            end else begin
                target <= eff_target;
                if (req != REQ_NONE) begin
                    shift_reject <= 1'b1;
                    reject_code  <= REJ_BUSY;
                end
                if (tick_speed && cnt != TICK_SAT)
                    cnt <= cnt + CNT_W'(1);
                // A vehicle still rolling at completion cannot engage P or R.
                if (tick_speed && cnt == TICK_LAST) begin
                    state <= ST_STABLE;
                    if (needs_standstill(eff_target) && speed != 8'd0) begin
                        current_gear <= GEAR_N;
                        shift_reject <= 1'b1;
                        reject_code  <= REJ_SPEED;
                    end else begin
                        current_gear <= eff_target;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench for gear_shift_ctrl: one task per scenario, inline checks
// against hand-computed gear, busy and reject values.
module tb_gear_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       engine_on;
    logic       tick_speed;
    logic       req_up;
    logic       req_down;
    logic       req_park;
    logic       brake;
    logic [7:0] speed;
    logic [7:0] fuel;
    logic [3:0] current_gear;
    logic       shift_busy;
    logic       shift_reject;
    logic [1:0] reject_code;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    gear_shift_ctrl #(.SHIFT_TICKS(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .engine_on    (engine_on),
        .tick_speed   (tick_speed),
        .req_up       (req_up),
        .req_down     (req_down),
        .req_park     (req_park),
        .brake        (brake),
        .speed        (speed),
        .fuel         (fuel),
        .current_gear (current_gear),
        .shift_busy   (shift_busy),
        .shift_reject (shift_reject),
        .reject_code  (reject_code)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic down, input logic park);
        req_up   = up;
        req_down = down;
        req_park = park;
        cyc();
        req_up   = 1'b0;
        req_down = 1'b0;
        req_park = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_speed = 1'b1;
            cyc();
            tick_speed = 1'b0;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; engine_on = 1'b1; tick_speed = 1'b0;
        req_up = 1'b0; req_down = 1'b0; req_park = 1'b0;
        brake = 1'b0; speed = 8'd0; fuel = 8'd50;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (current_gear !== 4'd3) begin errors++; $display("FAIL reset_gear: got %0d want 3", current_gear); end
        checks++;
        if (shift_busy !== 1'b0 || shift_reject !== 1'b0 || reject_code !== 2'd0) begin
            errors++; $display("FAIL reset_flags: busy=%0b rej=%0b code=%0d want 0/0/0", shift_busy, shift_reject, reject_code);
        end
    endtask

    task automatic test_brake_reject();
        brake = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (shift_reject !== 1'b1 || reject_code !== 2'd0 || current_gear !== 4'd3) begin
            errors++; $display("FAIL brake_reject: rej=%0b code=%0d gear=%0d want 1/0/3", shift_reject, reject_code, current_gear);
        end
        cyc();
        checks++;
        if (shift_reject !== 1'b0 || reject_code !== 2'd0) begin
            errors++; $display("FAIL brake_reject_len: rej=%0b code=%0d want 0/0", shift_reject, reject_code);
        end
    endtask

    task automatic test_ignored();
        brake = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (shift_reject !== 1'b0 || shift_busy !== 1'b0 || current_gear !== 4'd3) begin
            errors++; $display("FAIL down_in_p: rej=%0b busy=%0b gear=%0d want 0/0/3", shift_reject, shift_busy, current_gear);
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (shift_reject !== 1'b0 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL park_in_p: rej=%0b busy=%0b want 0/0", shift_reject, shift_busy);
        end
        pulse(1'b1, 1'b1, 1'b0);
        checks++;
        if (shift_reject !== 1'b0 || shift_busy !== 1'b0 || current_gear !== 4'd3) begin
            errors++; $display("FAIL up_and_down: rej=%0b busy=%0b gear=%0d want 0/0/3", shift_reject, shift_busy, current_gear);
        end
    endtask

    task automatic test_upshift();
        logic [3:0] want;
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd12);
        brake = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (current_gear !== 4'd9 || shift_busy !== 1'b1) begin
            errors++; $display("FAIL up_accept: gear=%0d busy=%0b want 9/1", current_gear, shift_busy);
        end
        do_ticks(3);
        checks++;
        if (current_gear !== 4'd9 || shift_busy !== 1'b1) begin
            errors++; $display("FAIL up_three_ticks: gear=%0d busy=%0b want 9/1", current_gear, shift_busy);
        end
        do_ticks(1);
        want = exp_q.pop_front();
        checks++;
        if (current_gear !== want || shift_busy !== 1'b0) begin
            errors++; $display("FAIL up_p_to_r: gear=%0d busy=%0b want %0d/0", current_gear, shift_busy, want);
        end
        pulse(1'b1, 1'b0, 1'b0);
        do_ticks(4);
        want = exp_q.pop_front();
        checks++;
        if (current_gear !== want || shift_busy !== 1'b0) begin
            errors++; $display("FAIL up_r_to_n: gear=%0d busy=%0b want %0d/0", current_gear, shift_busy, want);
        end
        // Tick coincident with the accept must not count.
        tick_speed = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        tick_speed = 1'b0;
        do_ticks(3);
        checks++;
        if (current_gear !== 4'd9 || shift_busy !== 1'b1) begin
            errors++; $display("FAIL accept_tick_ignored: gear=%0d busy=%0b want 9/1", current_gear, shift_busy);
        end
        do_ticks(1);
        want = exp_q.pop_front();
        checks++;
        if (current_gear !== want || shift_busy !== 1'b0) begin
            errors++; $display("FAIL up_n_to_d: gear=%0d busy=%0b want %0d/0", current_gear, shift_busy, want);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (shift_reject !== 1'b0 || shift_busy !== 1'b0 || current_gear !== 4'd12) begin
            errors++; $display("FAIL up_in_d: rej=%0b busy=%0b gear=%0d want 0/0/12", shift_reject, shift_busy, current_gear);
        end
    endtask

    task automatic test_downshift_last_fwd();
        speed = 8'd60;
        pulse(1'b0, 1'b1, 1'b0);
        do_ticks(4);
        checks++;
        if (current_gear !== 4'd9 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL d_to_n_moving: gear=%0d busy=%0b want 9/0", current_gear, shift_busy);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (shift_reject !== 1'b1 || reject_code !== 2'd1 || current_gear !== 4'd9 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL n_to_r_speed: rej=%0b code=%0d gear=%0d busy=%0b want 1/1/9/0", shift_reject, reject_code, current_gear, shift_busy);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (shift_busy !== 1'b1 || shift_reject !== 1'b0) begin
            errors++; $display("FAIL n_to_d_last_fwd: busy=%0b rej=%0b want 1/0", shift_busy, shift_reject);
        end
        do_ticks(4);
        checks++;
        if (current_gear !== 4'd12) begin errors++; $display("FAIL n_to_d_done: gear=%0d want 12", current_gear); end
    endtask

    task automatic test_busy_and_recheck();
        speed = 8'd0;
        pulse(1'b0, 1'b1, 1'b0);
        do_ticks(4);
        pulse(1'b0, 1'b1, 1'b0);
        do_ticks(1);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (shift_reject !== 1'b1 || reject_code !== 2'd2 || shift_busy !== 1'b1 || current_gear !== 4'd9) begin
            errors++; $display("FAIL busy_reject: rej=%0b code=%0d busy=%0b gear=%0d want 1/2/1/9", shift_reject, reject_code, shift_busy, current_gear);
        end
        do_ticks(3);
        checks++;
        if (current_gear !== 4'd6 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL busy_shift_done: gear=%0d busy=%0b want 6/0", current_gear, shift_busy);
        end
        pulse(1'b0, 1'b1, 1'b0);
        do_ticks(3);
        speed = 8'd5;
        tick_speed = 1'b1;
        cyc();
        tick_speed = 1'b0;
        checks++;
        if (current_gear !== 4'd9 || shift_busy !== 1'b0 || shift_reject !== 1'b1 || reject_code !== 2'd1) begin
            errors++; $display("FAIL recheck_speed: gear=%0d busy=%0b rej=%0b code=%0d want 9/0/1/1", current_gear, shift_busy, shift_reject, reject_code);
        end
        cyc();
        checks++;
        if (shift_reject !== 1'b0 || reject_code !== 2'd1) begin
            errors++; $display("FAIL recheck_pulse_len: rej=%0b code=%0d want 0/1", shift_reject, reject_code);
        end
        // Last direction was reverse, so N to D needs a standstill.
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (shift_reject !== 1'b1 || reject_code !== 2'd1 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL n_to_d_no_fwd: rej=%0b code=%0d busy=%0b want 1/1/0", shift_reject, reject_code, shift_busy);
        end
        speed = 8'd0;
    endtask

    task automatic test_engine_off();
        pulse(1'b1, 1'b0, 1'b0);
        do_ticks(4);
        checks++;
        if (current_gear !== 4'd12) begin errors++; $display("FAIL engine_setup_d: gear=%0d want 12", current_gear); end
        pulse(1'b0, 1'b1, 1'b0);
        do_ticks(1);
        engine_on = 1'b0;
        cyc();
        checks++;
        if (current_gear !== 4'd3 || shift_busy !== 1'b0 || shift_reject !== 1'b0) begin
            errors++; $display("FAIL engine_off_abort: gear=%0d busy=%0b rej=%0b want 3/0/0", current_gear, shift_busy, shift_reject);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (shift_reject !== 1'b1 || reject_code !== 2'd3 || current_gear !== 4'd3) begin
            errors++; $display("FAIL engine_reject: rej=%0b code=%0d gear=%0d want 1/3/3", shift_reject, reject_code, current_gear);
        end
        engine_on = 1'b1;
        cyc();
    endtask

    task automatic test_fuel();
        brake = 1'b1;
        pulse(1'b1, 1'b0, 1'b0); do_ticks(4);
        pulse(1'b1, 1'b0, 1'b0); do_ticks(4);
        pulse(1'b1, 1'b0, 1'b0); do_ticks(4);
        checks++;
        if (current_gear !== 4'd12) begin errors++; $display("FAIL fuel_setup_d: gear=%0d want 12", current_gear); end
        fuel = 8'd0;
        cyc();
        checks++;
        if (current_gear !== 4'd9 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL fuel_out_n: gear=%0d busy=%0b want 9/0", current_gear, shift_busy);
        end
        speed = 8'd40;
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (shift_reject !== 1'b1 || reject_code !== 2'd1 || current_gear !== 4'd9) begin
            errors++; $display("FAIL park_speed: rej=%0b code=%0d gear=%0d want 1/1/9", shift_reject, reject_code, current_gear);
        end
        speed = 8'd0;
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (shift_busy !== 1'b1 || current_gear !== 4'd9) begin
            errors++; $display("FAIL park_accept: busy=%0b gear=%0d want 1/9", shift_busy, current_gear);
        end
        do_ticks(4);
        checks++;
        if (current_gear !== 4'd3 || shift_busy !== 1'b0) begin
            errors++; $display("FAIL park_done: gear=%0d busy=%0b want 3/0", current_gear, shift_busy);
        end
        fuel = 8'd50;
    endtask

    initial begin
        test_reset();
        test_brake_reject();
        test_ignored();
        test_upshift();
        test_downshift_last_fwd();
        test_busy_and_recheck();
        test_engine_off();
        test_fuel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gear_shift_ctrl.md
Name: gear_shift_ctrl

Overview:
Gear selector sequencer. It turns debounced driver shift requests into the `current_gear` code (3=P, 6=R, 9=N, 12=D) that drives the vehicle physics/RPM datapath. It enforces brake and speed interlocks and inserts a timed neutral phase on every shift. It forces safe gears on engine-off and fuel-out, and reports rejected requests for the buzzer/LED block.

Parameters:
SHIFT_TICKS, 4, number of tick_speed pulses spent in neutral during a shift; legal range 1..15
CNT_W, 4, width of the shift tick counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
engine_on  input  1  engine running
tick_speed  input  1  one-cycle physics tick strobe
req_up  input  1  one-cycle pulse, step toward D (P→R→N→D)
req_down  input  1  one-cycle pulse, step toward P (D→N→R→P)
req_park  input  1  one-cycle pulse, go directly to P
brake  input  1  any brake pressed (normal or hard)
speed  input  8  current speed, km/h
fuel  input  8  fuel level, %
current_gear  output  4  gear code 3/6/9/12, registered
shift_busy  output  1  high while a shift is in progress
shift_reject  output  1  one-cycle pulse on a refused request
reject_code  output  2  0=BRAKE, 1=SPEED, 2=BUSY, 3=ENGINE; valid with shift_reject, holds its last value otherwise

Behaviour:
- Reset: current_gear=3 (P), shift_busy=0, shift_reject=0, reject_code=0, FSM=STABLE, counter=0, last_fwd=0.
- FSM states: STABLE, SHIFT.
- Request priority in a cycle: req_park > (req_up XOR req_down). If req_up and req_down arrive together without req_park, both are ignored silently.
- Stepping past the end of the range is ignored silently, with no pulse: req_up in D, req_down in P, req_park in P.
- Interlocks are evaluated at the request cycle against the current gear. The first failing rule wins, in this order:
  - engine_on=0: all requests rejected with ENGINE.
  - Leaving P: brake must be 1, else BRAKE.
  - Target P or R: speed must be 0, else SPEED.
  - N→D: requires speed==0 or last_fwd=1, else SPEED. last_fwd is set while in D and cleared while in R.
- Accept in STABLE at cycle t:
  - From t+1: current_gear=9, shift_busy=1, target latched, counter=0.
  - The counter increments on each tick_speed while in SHIFT.
  - On the cycle after the SHIFT_TICKS-th tick, current_gear=target, shift_busy=0, FSM→STABLE.
- Completion recheck: if the target is P or R and speed≠0 at completion, the FSM lands in N (9) and pulses shift_reject with SPEED.
- Any request while in SHIFT: shift_reject pulse, code BUSY; the shift continues unaffected.
- A reject pulse appears the cycle after the request (registered) and lasts exactly one cycle.
- engine_on=0 in any state, including mid-shift: the next cycle gives current_gear=3, shift_busy=0, FSM=STABLE, and the counter is cleared. No reject pulse.
- fuel==0 while STABLE in D or R: the next cycle gives current_gear=9 immediately, with no neutral delay.
- fuel==0 in SHIFT with target D or R: the target is retargeted to N.
- A simultaneous tick_speed and request on the accept cycle is not counted. Counting starts in SHIFT.
- The counter saturates at SHIFT_TICKS; there is no wrap.

Decomposition:
- Shared package vehicle_pkg holds:
  - gear codes GEAR_P=4'd3, GEAR_R=4'd6, GEAR_N=4'd9, GEAR_D=4'd12
  - reject codes REJ_BRAKE/REJ_SPEED/REJ_BUSY/REJ_ENGINE
  - the FSM state encoding
- Sub-module gear_interlock_check: purely combinational. It takes current gear, request, brake, speed, engine_on and last_fwd, and returns accept, target and code.
- The top level holds the FSM, the counter and the output registers.

Test Plan:
- Reset, engine_on=1, brake=0, req_up → shift_reject=1 for 1 cycle, reject_code=0 (BRAKE), gear stays 3.
- brake=1, req_up → gear 9 and busy=1 for 4 tick_speed pulses, then gear=6, busy=0. Then req_up ×2 (each after completion) → gear 12.
- In D at speed=60, req_down → gear 9 after the shift. req_down again → reject SPEED, gear stays 9. req_up → gear 12 (last_fwd path).
- Mid-shift N→R: second req_down during SHIFT → reject BUSY, shift completes to 6. Then drive speed to 5 at completion of R→P → lands in 9 with reject SPEED.
- In D mid-shift, drop engine_on → next cycle gear=3, busy=0, no reject pulse. With engine off, req_up → reject ENGINE.
- In D, fuel drops to 0 → next cycle gear=9, no delay. req_park at speed=40 → reject SPEED. At speed=0 → P after 4 ticks.
